maxpool_window_buffer: RTL
==========================

# maxpool_window_buffer

Streaming window assembler that drives the 2x2 max-pool stage. It accepts conv/activation output pixels one per cycle in raster order and buffers one image row. It emits a registered 2x2 window plus a one-cycle `window_valid` strobe, which connects directly to the pool stage's window input and `enable`. It also tracks pooled-output coordinates and frame completion so that downstream FIFOs and the BiLSTM feature packer can index pooled pixels.

## Interface
- `DATA_WIDTH`, 16, pixel bit width; values are passed through unmodified.
- `MAX_POOL_KERNEL`, 2, window size; only 2 is supported.
- `IMG_WIDTH`, 32, input pixels per row; must be ≥ 2.
- `IMG_HEIGHT`, 32, input rows per frame; must be ≥ 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pixel_in`  in  DATA_WIDTH  input pixel.
- `pixel_valid`  in  1  `pixel_in` is accepted on this edge. There is no backpressure; every valid pixel is consumed.
- `maxpool_fifo_out`  out  DATA_WIDTH × [MAX_POOL_KERNEL][MAX_POOL_KERNEL]  window; [r][c] means row r, column c of the window.
- `window_valid`  out  1  one-cycle strobe; the window is complete. Drives the pool `enable`.
- `out_row`  out  $clog2(IMG_HEIGHT/2)+1  pooled row index of the current window.
- `out_col`  out  $clog2(IMG_WIDTH/2)+1  pooled column index of the current window.
- `frame_done`  out  1  one-cycle strobe, coincident with the last `window_valid` of a frame.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance only on accepted pixels. `col` wraps to 0 and increments `row`. At (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0, and the next frame starts with no idle cycle.
- FSM with two states, FILL_TOP and FILL_BOTTOM:
  - FILL_TOP (even `row`): write `pixel_in` into the line buffer at `col`. No window is produced.
  - FILL_BOTTOM (odd `row`): on even `col`, hold `pixel_in` in the `left` register. On odd `col`, load the window and assert `window_valid`:
    - [0][0] = `linebuf[col-1]`
    - [0][1] = `linebuf[col]`
    - [1][0] = `left`
    - [1][1] = `pixel_in`
  - Transition FILL_TOP→FILL_BOTTOM on acceptance of the last pixel of an even row. Transition FILL_BOTTOM→FILL_TOP on acceptance of the last pixel of an odd row.
- Odd dimensions use floor behaviour:
  - Odd IMG_WIDTH: the last column is accepted and counted but never windowed.
  - Odd IMG_HEIGHT: the last row is written into the line buffer and never windowed.
- `out_row` = `row`>>1 and `out_col` = `col`>>1, both registered with the window.
- `frame_done` is asserted with the window at `out_row` = IMG_HEIGHT/2−1 and `out_col` = IMG_WIDTH/2−1.
- Line buffer: IMG_WIDTH × DATA_WIDTH registers, read and written in the same cycle. Read-before-write is not needed because top and bottom rows never overlap.

## Timing
- Reset (asynchronous, any cycle): every output goes to 0, all window entries go to 0, counters go to 0, FSM goes to FILL_TOP, and `left` goes to 0. Line-buffer contents are don't-care after reset.
  - Reset mid-frame discards the partial frame.
  - The first pixel accepted after reset deasserts is (row 0, col 0).
- Latency: `window_valid` is high the cycle after the edge that accepts the completing pixel (odd col, odd row). The pool result appears one cycle after that.
- `window_valid` and `frame_done` stay high for exactly one cycle.
- `maxpool_fifo_out`, `out_row` and `out_col` hold their last values until the next window.
- Gaps in `pixel_valid` stall the counters and FSM with no state change.
- Maximum window rate is one every 2 accepted pixels.
- `pixel_valid` low on the completing cycle means no window is produced; the window fires when that pixel is eventually accepted.

## Test plan
- Frame order, back-to-back: IMG_WIDTH=4, IMG_HEIGHT=4; pixels 1..16 with `pixel_valid` held high.
  - Required windows, in order: {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16}.
  - (`out_row`,`out_col`) = (0,0), (0,1), (1,0), (1,1).
  - `frame_done` asserted only with the 4th window.
  - Each window arrives 1 cycle after the completing pixel.
- Stall tolerance: same frame with `pixel_valid` toggled pseudo-randomly at a 50% duty cycle.
  - Identical window contents and order to the back-to-back case.
  - `window_valid` never high on two consecutive cycles.
- Odd dimensions: IMG_WIDTH=5, IMG_HEIGHT=3; pixels 1..15.
  - Windows exactly {1,2,6,7} and {3,4,8,9}.
  - Pixels 5, 10 and row 2 are never windowed.
  - `frame_done` asserted with the 2nd window.
- Async reset mid-frame: assert `rst` mid-cycle after 6 pixels of a 4×4 frame.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh 1..16 frame yields the same 4 windows as the frame-order test.
- Consecutive frames: two frames streamed with no gap, values 1..16 then 101..116.
  - Second frame windows {101,102,105,106} … {111,112,115,116}, with `out_row`/`out_col` restarting at 0.
  - Exactly two `frame_done` pulses.
- Signed passthrough: window values 0x8000, 0xFFFF, 0x7FFF, 0x0001 pass bit-exact to `maxpool_fifo_out`.

Source files
------------

// File: rtl/maxpool_window_buffer.sv
// rtl/maxpool_window_buffer.sv - one-row line buffer assembling 2x2 max-pool windows from a raster pixel stream
// Emits a registered window with a one-cycle strobe, pooled coordinates and an end-of-frame marker.
module maxpool_window_buffer #(
   parameter int DATA_WIDTH      = 16,
   parameter int MAX_POOL_KERNEL = 2,
   parameter int IMG_WIDTH       = 32,
   parameter int IMG_HEIGHT      = 32
) (
   input  logic                                                        clk,
   input  logic                                                        rst,
   input  logic [DATA_WIDTH-1:0]                                       pixel_in,
   input  logic                                                        pixel_valid,
   output logic [MAX_POOL_KERNEL-1:0][MAX_POOL_KERNEL-1:0][DATA_WIDTH-1:0] maxpool_fifo_out,
   output logic                                                        window_valid,
   output logic [$clog2(IMG_HEIGHT/2):0]                               out_row,
   output logic [$clog2(IMG_WIDTH/2):0]                                out_col,
   output logic                                                        frame_done
);

   localparam int COL_W  = $clog2(IMG_WIDTH);
   localparam int ROW_W  = $clog2(IMG_HEIGHT);
   localparam int OROW_W = $clog2(IMG_HEIGHT/2) + 1;
   localparam int OCOL_W = $clog2(IMG_WIDTH/2) + 1;

   typedef enum logic {FILL_TOP, FILL_BOTTOM} state_t;

   state_t                  state, state_next;
   logic [COL_W-1:0]        col;
   logic [COL_W-1:0]        col_prev;
   logic [ROW_W-1:0]        row;
   logic [DATA_WIDTH-1:0]   linebuf [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   left;
   logic                    last_col, last_row, win_last;
   logic                    lb_we, left_we, win_load;

   assign last_col = (col == COL_W'(IMG_WIDTH - 1));
   assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));
   assign col_prev = col - COL_W'(1);
   assign win_last = ((row >> 1) == ROW_W'(IMG_HEIGHT/2 - 1)) &&
                     ((col >> 1) == COL_W'(IMG_WIDTH/2 - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FILL_TOP;
      else     state <= state_next;
   end

   // An odd-height frame ends on an even row, so the wrap must force FILL_TOP.
   always_comb begin
      state_next = state;
      if (pixel_valid && last_col) begin
         if (last_row)                state_next = FILL_TOP;
         else if (state == FILL_TOP)  state_next = FILL_BOTTOM;
         else                         state_next = FILL_TOP;
      end
   end

   always_comb begin
      lb_we    = 1'b0;
      left_we  = 1'b0;
      win_load = 1'b0;
      case (state)
         FILL_TOP:    lb_we = pixel_valid;
         FILL_BOTTOM: begin
            left_we  = pixel_valid && !col[0];
            win_load = pixel_valid &&  col[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (pixel_valid) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (lb_we) linebuf[col] <= pixel_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left             <= '0;
         maxpool_fifo_out <= '0;
         window_valid     <= 1'b0;
         frame_done       <= 1'b0;
         out_row          <= '0;
         out_col          <= '0;
      end else begin
         window_valid <= win_load;
         frame_done   <= win_load && win_last;
         if (left_we) left <= pixel_in;
         if (win_load) begin
            maxpool_fifo_out[0][0] <= linebuf[col_prev];
            maxpool_fifo_out[0][1] <= linebuf[col];
            maxpool_fifo_out[1][0] <= left;
            maxpool_fifo_out[1][1] <= pixel_in;
            out_row                <= OROW_W'(row >> 1);
            out_col                <= OCOL_W'(col >> 1);
         end
      end
   end

endmodule
